// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file sequencer: FSM state
// encoding, strobe/enable polarities and default widths.
package regfile_sched_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_STARVE_LIMIT = 4;

  // The register file's read/write enables are active low; strobes are active high.
  localparam logic RF_EN_ACTIVE  = 1'b0;
  localparam logic RF_EN_IDLE    = 1'b1;
  localparam logic RF_STB_ACTIVE = 1'b1;
  localparam logic RF_STB_IDLE   = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    W_SET,
    W_STB,
    R_SET,
    R_STB,
    R_CAP,
    RSP
  } regfile_sched_state_t;

endpackage

// File: rtl/regfile_sched_arb.sv
// Write/read arbiter: write wins by default, a pending read is forced after
// STARVE_LIMIT write grants unless the write targets one of its sources.
module regfile_sched_arb
  import regfile_sched_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idle,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_rd,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_rs1,
  input  logic [ADDR_W-1:0] rd_rs2,
  output logic              wr_grant,
  output logic              rd_grant
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             hazard;
  logic             rd_wins;

  always_comb begin
    // NOTE: every output gets a default first so no path can leave one unassigned and infer a latch.
    hazard   = 1'b0;
    rd_wins  = 1'b0;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (wr_rd != '0 && (wr_rd == rd_rs1 || wr_rd == rd_rs2)) hazard = 1'b1;
    if (rd_valid && (!wr_valid || (starve_cnt == CNT_MAX && !hazard))) rd_wins = 1'b1;
    if (idle) begin
      rd_grant = rd_wins;
      wr_grant = wr_valid && !rd_wins;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (rd_grant) begin
      starve_cnt <= '0;
    end else if (wr_grant && rd_valid && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_sched.sv
// Register-file sequencer: turns valid/ready requests into set-up/strobe
// sequences on the unclocked register file and returns registered operands.
module regfile_sched
  import regfile_sched_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_rd,
  input  logic [DATA_W-1:0] wr_value,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_rs1,
  input  logic [ADDR_W-1:0] rd_rs2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs1_value,
  output logic [DATA_W-1:0] rsp_rs2_value,
  output logic              busy,
  output logic              rf_req_r,
  output logic              rf_req_w,
  output logic              rf_rs_read_n,
  output logic              rf_rd_write_n,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_rd_value,
  input  logic [DATA_W-1:0] rf_rs1_value,
  input  logic [DATA_W-1:0] rf_rs2_value
);

  regfile_sched_state_t state;
  logic                 wr_grant;
  logic                 rd_grant;

  regfile_sched_arb #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .idle    (state == IDLE),
    .wr_valid(wr_valid),
    .wr_rd   (wr_rd),
    .rd_valid(rd_valid),
    .rd_rs1  (rd_rs1),
    .rd_rs2  (rd_rs2),
    .wr_grant(wr_grant),
    .rd_grant(rd_grant)
  );

  assign wr_ready = wr_grant;
  assign rd_ready = rd_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      rf_req_r      <= RF_STB_IDLE;
      rf_req_w      <= RF_STB_IDLE;
      rf_rs_read_n  <= RF_EN_IDLE;
      rf_rd_write_n <= RF_EN_IDLE;
      rf_rs1        <= '0;
      rf_rs2        <= '0;
      rf_rd         <= '0;
      rf_rd_value   <= '0;
      rsp_valid     <= 1'b0;
      rsp_rs1_value <= '0;
      rsp_rs2_value <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_grant) begin
            state        <= R_SET;
            busy         <= 1'b1;
            rf_rs1       <= rd_rs1;
            rf_rs2       <= rd_rs2;
            rf_rs_read_n <= RF_EN_ACTIVE;
          end else if (wr_grant && wr_rd != '0) begin
            // r0 is hardwired to zero: such writes are acknowledged without a strobe.
            state         <= W_SET;
            busy          <= 1'b1;
            rf_rd         <= wr_rd;
            rf_rd_value   <= wr_value;
            rf_rd_write_n <= RF_EN_ACTIVE;
          end
        end
        W_SET: begin
          state    <= W_STB;
          rf_req_w <= RF_STB_ACTIVE;
        end
        W_STB: begin
          state         <= IDLE;
          busy          <= 1'b0;
          rf_req_w      <= RF_STB_IDLE;
          rf_rd_write_n <= RF_EN_IDLE;
        end
        R_SET: begin
          state    <= R_STB;
          rf_req_r <= RF_STB_ACTIVE;
        end
        R_STB: begin
          state    <= R_CAP;
          rf_req_r <= RF_STB_IDLE;
        end
        R_CAP: begin
          state         <= RSP;
          rf_rs_read_n  <= RF_EN_IDLE;
          rsp_valid     <= 1'b1;
          rsp_rs1_value <= rf_rs1_value;
          rsp_rs2_value <= rf_rs2_value;
        end
        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// Bench for regfile_sched: register-file model, operand scoreboard,
// arbitration vector table and hand-written timing/starvation/reset sequences.
module tb_regfile_sched;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_value;
  logic              rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_rs1, rd_rs2;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rs1_value, rsp_rs2_value;
  logic              busy, rf_req_r, rf_req_w, rf_rs_read_n, rf_rd_write_n;
  logic [ADDR_W-1:0] rf_rs1, rf_rs2, rf_rd;
  logic [DATA_W-1:0] rf_rd_value, rf_rs1_value, rf_rs2_value;

  regfile_sched dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_rd(wr_rd), .wr_value(wr_value),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs1_value(rsp_rs1_value), .rsp_rs2_value(rsp_rs2_value),
    .busy(busy), .rf_req_r(rf_req_r), .rf_req_w(rf_req_w),
    .rf_rs_read_n(rf_rs_read_n), .rf_rd_write_n(rf_rd_write_n),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_rd_value(rf_rd_value),
    .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return (i == 0) ? 32'h0 : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
  endfunction

  // Register-file model: write on strobe with enable, read data latched on read strobe.
  logic [DATA_W-1:0] rf_mem [32];
  bit                mem_init;
  int                w_pulses = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end
    if (rf_req_w && rf_rd_write_n == 1'b0 && rf_rd != '0) rf_mem[rf_rd] <= rf_rd_value;
    if (rf_req_r && rf_rs_read_n == 1'b0) begin
      rf_rs1_value <= rf_mem[rf_rs1];
      rf_rs2_value <= rf_mem[rf_rs2];
    end
    if (rf_req_w) w_pulses <= w_pulses + 1;
  end

  // Architectural reference and operand scoreboard, sampled on the falling edge.
  logic [DATA_W-1:0] arch [32];
  bit                arch_init;
  logic [63:0]       sb[$];
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!arch_init) begin
      for (int i = 0; i < 32; i++) arch[i] <= init_val(i);
      arch_init <= 1'b1;
    end
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("one_ready", 64'(wr_ready & rd_ready), 64'd0);
      if (wr_valid && wr_ready && wr_rd != '0) arch[wr_rd] <= wr_value;
      if (rd_valid && rd_ready) sb.push_back({arch[rd_rs1], arch[rd_rs2]});
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("rsp_rs1", 64'(rsp_rs1_value), 64'(exp[63:32]));
          check("rsp_rs2", 64'(rsp_rs2_value), 64'(exp[31:0]));
        end
      end
    end
  end

  // Present a request until one side is granted, let it fire, then withdraw.
  task automatic offer(input bit wv, input logic [ADDR_W-1:0] wrd, input logic [DATA_W-1:0] wval,
                       input bit rv, input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                       output bit got_w, output bit got_r);
    got_w = 1'b0;
    got_r = 1'b0;
    @(posedge clk); #1;
    wr_valid = wv; wr_rd = wrd; wr_value = wval;
    rd_valid = rv; rd_rs1 = rs1; rd_rs2 = rs2;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wr_ready || rd_ready) begin
        got_w = wr_ready;
        got_r = rd_ready;
        break;
      end
    end
    check("offer_granted", 64'(got_w | got_r), 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) done = 1'b1;
    end
    check("idle_reached", 64'(done), 64'd1);
  endtask

  typedef struct {
    bit                wv;
    logic [ADDR_W-1:0] wrd;
    logic [DATA_W-1:0] wval;
    bit                rv;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    bit                exp_w;
    bit                exp_r;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit gw, gr;
    int n_w, p0;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit gw, gr;
    int n_w, p0;
    bit seen;

    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5, 5'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 5'd5, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 5'd3,  32'h0000_0033, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 5'd4,  32'h0000_0044, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 5'd6,  32'h0000_0066, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 5'd8,  32'h0000_0088, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 5'd9,  32'h0000_0099, 1'b1, 5'd3, 5'd4, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd9, 5'd8, 1'b0, 1'b1};

    rst_n = 1'b0;
    wr_valid = 1'b0; wr_rd = '0; wr_value = '0;
    rd_valid = 1'b0; rd_rs1 = '0; rd_rs2 = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 64'({rf_req_r, rf_req_w, rsp_valid, busy, rf_rs_read_n, rf_rd_write_n}),
          64'(6'b000011));
    check("rst_addr", 64'({rf_rs1, rf_rs2, rf_rd}), 64'd0);
    check("rst_data", 64'({rf_rd_value, rsp_rs1_value}), 64'd0);
    check("rst_rsp2", 64'(rsp_rs2_value), 64'd0);
    rst_n = 1'b1;

    // Arbitration table: grant side and strobe count per vector.
    for (int v = 0; v < 10; v++) begin
      p0 = w_pulses;
      offer(vecs[v].wv, vecs[v].wrd, vecs[v].wval, vecs[v].rv, vecs[v].rs1, vecs[v].rs2, gw, gr);
      check($sformatf("vec%0d_wr_ready", v), 64'(gw), 64'(vecs[v].exp_w));
      check($sformatf("vec%0d_rd_ready", v), 64'(gr), 64'(vecs[v].exp_r));
      wait_idle();
      check($sformatf("vec%0d_wr_pulses", v), 64'(w_pulses - p0),
            64'(vecs[v].exp_w && vecs[v].wrd != '0));
    end

    // Write sequence timing.
    offer(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, gw, gr);
    @(negedge clk);
    check("w_t1", 64'({rf_req_w, rf_rd_write_n, rf_rd, rf_rd_value}), 64'({2'b00, 5'd5, 32'hDEAD_BEEF}));
    @(negedge clk);
    check("w_t2", 64'({rf_req_w, rf_rd_write_n, rf_rd, rf_rd_value}), 64'({2'b10, 5'd5, 32'hDEAD_BEEF}));
    @(negedge clk);
    check("w_t3", 64'({rf_req_w, rf_rd_write_n, busy}), 64'(3'b010));

    // Read latency: response at T+4.
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, gw, gr);
    @(negedge clk);
    check("r_t1", 64'({rsp_valid, rf_req_r, rf_rs_read_n, rf_rs1}), 64'({3'b000, 5'd5}));
    @(negedge clk);
    check("r_t2", 64'({rsp_valid, rf_req_r, rf_rs_read_n}), 64'(3'b010));
    @(negedge clk);
    check("r_t3", 64'({rsp_valid, rf_req_r, rf_rs_read_n}), 64'(3'b000));
    @(negedge clk);
    check("r_t4", 64'({rsp_valid, rf_req_r, rf_rs_read_n}), 64'(3'b101));
    wait_idle();

    // Starvation: held read wins after exactly four write grants.
    n_w = 0;
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 5'(20 + i), 32'h2000_0000 + 32'(i), 1'b1, 5'd1, 5'd2, gw, gr);
      if (gr) break;
      n_w++;
    end
    check("starve_writes", 64'(n_w), 64'd4);
    wait_idle();

    // Counter cleared: four more writes, then a hazard at the limit still goes to the write.
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'(24 + i), 32'h2400_0000 + 32'(i), 1'b1, 5'd1, 5'd7, gw, gr);
      check($sformatf("refill%0d_wr", i), 64'(gw), 64'd1);
    end
    offer(1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd1, 5'd7, gw, gr);
    check("hazard_wr_wins", 64'({gw, gr}), 64'(2'b10));
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd7, gw, gr);
    check("hazard_rd_after", 64'(gr), 64'd1);
    wait_idle();

    // Backpressure: response held stable, no new read accepted.
    rsp_ready = 1'b0;
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4, gw, gr);
    rd_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    check("bp_rsp_seen", 64'(seen), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold", 64'({rsp_valid, rd_ready, busy}), 64'(3'b101));
      check("bp_values", {rsp_rs1_value, rsp_rs2_value}, {32'h0000_0033, 32'h0000_0044});
    end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during R_STB aborts the read and drops its response.
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6, gw, gr);
    @(posedge clk); #1;
    check("rstb_req_r", 64'(rf_req_r), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst", 64'({rsp_valid, rf_rs_read_n, busy, rf_req_r}), 64'(4'b0100));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_rsp", 64'(rsp_valid), 64'd0);

    // Recovery read after reset.
    offer(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd20, gw, gr);
    check("recover_rd", 64'(gr), 64'd1);
    wait_idle();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sched.md
Name: regfile_sched

Overview:
Sequencer and arbiter for the CPU register file, which has no clock of its own. It turns the register file's strobe-driven ports into clocked valid/ready handshakes. It arbitrates between the writeback stage (write requester) and the decode stage (read requester). It generates properly set-up req_w/req_r strobes and active-low enables, and registers the read operands for decode.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width
STARVE_LIMIT, 4, consecutive write grants allowed while a read is pending before the read is forced

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  writeback request valid
wr_ready  out  1  write request accepted this cycle
wr_rd  in  ADDR_W  destination register index
wr_value  in  DATA_W  write data
rd_valid  in  1  decode read request valid
rd_ready  out  1  read request accepted this cycle
rd_rs1  in  ADDR_W  source 1 index
rd_rs2  in  ADDR_W  source 2 index
rsp_valid  out  1  operand response valid
rsp_ready  in  1  decode consumes response
rsp_rs1_value  out  DATA_W  source 1 value
rsp_rs2_value  out  DATA_W  source 2 value
busy  out  1  state != IDLE
rf_req_r  out  1  register-file read strobe (registered)
rf_req_w  out  1  register-file write strobe (registered)
rf_rs_read_n  out  1  read enable, active low
rf_rd_write_n  out  1  write enable, active low
rf_rs1, rf_rs2, rf_rd  out  ADDR_W  register-file addresses
rf_rd_value  out  DATA_W  register-file write data
rf_rs1_value, rf_rs2_value  in  DATA_W  register-file outputs

Behaviour:
- One clock. Reset is synchronous and active-low: on clk edge with rst_n=0 the state goes to IDLE. Reset values:
  - rf_req_r, rf_req_w, rsp_valid, busy: 0
  - rf_rs_read_n, rf_rd_write_n: 1
  - all addresses, rf_rd_value, rsp values, starve counter: 0
- States: IDLE, W_SET, W_STB, R_SET, R_STB, R_CAP, RSP.
- Handshakes fire only in IDLE. wr_ready/rd_ready are combinational from state and arbitration. At most one is high per cycle.
- Arbitration in IDLE: write wins by default. Read wins when rd_valid and either wr_valid=0, or starve_cnt==STARVE_LIMIT with no hazard.
  - Hazard: wr_rd!=0 and (wr_rd==rd_rs1 or wr_rd==rd_rs2). On a hazard the write still wins, even at the limit.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each write grant while rd_valid=1.
  - Clears on read grant.
- Write fire at edge T:
  - wr_rd==0: no strobe. Stay IDLE; the write counts as granted.
  - wr_rd!=0: address and data are latched onto rf_rd/rf_rd_value. Cycle T+1 is W_SET: rf_rd_write_n=0, strobe low. Cycle T+2 is W_STB: rf_req_w=1, rf_rd_write_n=0. Cycle T+3 is IDLE with outputs deasserted. rf_rd/rf_rd_value are held until the next write fire.
- Read fire at edge T:
  - Cycle T+1 is R_SET: rf_rs1/rf_rs2 driven, rf_rs_read_n=0.
  - Cycle T+2 is R_STB: rf_req_r=1.
  - Cycle T+3 is R_CAP: rf_rs*_value are captured into rsp regs at the end of the cycle.
  - From T+4 the state is RSP with rsp_valid=1 and values stable until rsp_ready=1. It then returns to IDLE on the next edge.
  - Read-to-response latency with rsp_ready held high: 4 cycles. Requests are not accepted during RSP.
- Simultaneous wr_valid and rd_valid: exactly one is granted per the arbitration rule above. The loser's request must be held by its requester.
- Reset mid-operation: abort to IDLE, drop any response. A strobe already raised is a completed access. A write reset during W_SET is not performed.

Decomposition:
- Package regfile_sched_pkg holds:
  - state enum regfile_sched_state_t
  - localparams for the strobe and enable polarities (RF_EN_ACTIVE=1'b0)
  - default widths
- One sub-module, regfile_sched_arb: combinational grant, hazard detect and the saturating starve counter.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Write only: wr_rd=5, wr_value=0xDEADBEEF -> rf_req_w high exactly at T+2, rf_rd=5 and rf_rd_write_n=0 during T+1..T+2.
- Write-then-read: write r5=0xDEADBEEF, then read rs1=5, rs2=0 with a register-file model -> rsp_valid at T+4 with rs1 value 0xDEADBEEF and rs2 value 0.
- Write to r0: wr_rd=0 -> wr_ready=1 and no rf_req_w pulse. A subsequent read of r0 returns 0.
- Starvation: wr_valid held with a new rd≠rs every cycle plus rd_valid held -> read is granted after exactly 4 writes; starve counter clears.
- Hazard at limit: starve counter=4, wr_rd=7, rd_rs2=7 -> write granted first; read returns the new r7 value.
- Backpressure and reset: rsp_ready=0 for 10 cycles -> response held stable and rd_ready=0. Then rst_n=0 during R_STB -> next cycle IDLE, rsp_valid=0, rf_rs_read_n=1.
